// File: rtl/regarb_pkg.sv
// Shared types and round-robin helper for the RegFile write-port arbiter.
// Optional conflict counter in the top is enabled by REGARB_CONFLICT_CNT_EN.
package regarb_pkg;

    localparam int W_DEF      = 8;
    localparam int A_DEF      = 2;
    localparam int NREQ_MAX   = 4;
    localparam int NREQ_IDX_W = $clog2(NREQ_MAX);

    typedef struct packed {
        logic [A_DEF-1:0] addr;
        logic [W_DEF-1:0] data;
        logic             upp_or_low;
    } wr_req_t;

    // One-hot grant: first full slot at or after ptr, wrapping modulo nreq.
    function automatic logic [NREQ_MAX-1:0] rr_pick(
        input logic [NREQ_MAX-1:0] full,
        input int unsigned         ptr,
        input int unsigned         nreq
    );
        logic [NREQ_MAX-1:0] grant;
        logic                found;
        int unsigned         idx;
        grant = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NREQ_MAX; k++) begin
            idx = ptr + k;
            if (idx >= nreq) idx = idx - nreq;
            if (k < nreq && !found && full[idx[NREQ_IDX_W-1:0]]) begin
                grant[idx[NREQ_IDX_W-1:0]] = 1'b1;
                found                      = 1'b1;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester-side handshake bundle: master = writeback sources, slave = arbiter.
interface regfile_write_arbiter_if
    import regarb_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int A    = A_DEF,
    parameter int W    = W_DEF
);

    logic [NREQ-1:0]        ReqValid;
    logic [NREQ-1:0]        ReqReady;
    logic [NREQ-1:0][A-1:0] ReqAddr;
    logic [NREQ-1:0][W-1:0] ReqData;
    logic [NREQ-1:0]        ReqUppOrLow;

    modport master (
        output ReqValid, ReqAddr, ReqData, ReqUppOrLow,
        input  ReqReady
    );

    modport slave (
        input  ReqValid, ReqAddr, ReqData, ReqUppOrLow,
        output ReqReady
    );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// NREQ-wide round-robin arbiter with its own rotating priority pointer.
// Pointer moves to one past the granted index; holds when nothing is granted.
module rr_arbiter
    import regarb_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] full,
    output logic [NREQ-1:0] grant
);

    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    ptr_d;
    logic [NREQ_MAX-1:0] pick;

    always_comb begin
        pick  = rr_pick(NREQ_MAX'(full), 32'(ptr_q), NREQ);
        grant = pick[NREQ-1:0];
    end

    if (NREQ < NREQ_MAX) begin : g_pad
        logic unused_pick;
        assign unused_pick = |pick[NREQ_MAX-1:NREQ];
    end

    // NOTE: assign the default before the loop so every path drives ptr_d and no latch is inferred.
    always_comb begin
        ptr_d = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) ptr_d = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
        end
    end

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single RegFile write port between NREQ one-entry holding slots.
// Define REGARB_CONFLICT_CNT_EN to add the saturating ConflictCnt output.
module regfile_write_arbiter
    import regarb_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int A    = A_DEF,
    parameter int NREQ = 2
) (
    input  logic                    Clk,
    input  logic                    Reset,
    regfile_write_arbiter_if.slave  req,
    output logic                    WriteEn,
    output logic [A-1:0]            Waddr,
    output logic [W-1:0]            DataIn,
    output logic                    UppOrLow,
    output logic                    Idle
`ifdef REGARB_CONFLICT_CNT_EN
    ,
    output logic [15:0]             ConflictCnt
`endif
);

    typedef struct packed {
        logic [A-1:0] addr;
        logic [W-1:0] data;
        logic         upp_or_low;
    } slot_t;

    logic [NREQ-1:0] slot_full;
    logic [NREQ-1:0] grant;
    logic [NREQ-1:0] ready;
    logic [NREQ-1:0] take;
    slot_t           slot_q [NREQ];
    slot_t           sel;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk   (Clk),
        .rst_n (Reset),
        .full  (slot_full),
        .grant (grant)
    );

    // A slot being drained this edge can accept its next entry on the same edge.
    assign ready         = ~slot_full | grant;
    assign take          = req.ReqValid & ready;
    assign req.ReqReady  = ready;

    always_ff @(posedge Clk) begin
        if (!Reset) slot_full <= '0;
        else        slot_full <= take | (slot_full & ~grant);
    end

    // NOTE: payload storage is not reset; slot_full alone says whether it is meaningful.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (take[i]) begin
                slot_q[i] <= '{addr:       req.ReqAddr[i],
                               data:       req.ReqData[i],
                               upp_or_low: req.ReqUppOrLow[i]};
            end
        end
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) sel = slot_q[i];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            WriteEn  <= 1'b0;
            Waddr    <= '0;
            DataIn   <= '0;
            UppOrLow <= 1'b0;
        end else begin
            WriteEn <= |grant;
            if (|grant) begin
                Waddr    <= sel.addr;
                DataIn   <= sel.data;
                UppOrLow <= sel.upp_or_low;
            end
        end
    end

    assign Idle = ~|slot_full & ~WriteEn;

`ifdef REGARB_CONFLICT_CNT_EN
    logic [15:0] conflict_cnt;
    logic        conflict;

    // More than one bit set: clearing the lowest set bit leaves something behind.
    assign conflict = |(slot_full & (slot_full - NREQ'(1)));

    always_ff @(posedge Clk) begin
        if (!Reset)                                conflict_cnt <= '0;
        else if (conflict && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
    end

    assign ConflictCnt = conflict_cnt;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench: stimulus queues expected writes in grant order,
// a negedge monitor pops and compares every WriteEn cycle.
module tb_regfile_write_arbiter;
    import regarb_pkg::*;

    localparam int NREQ = 2;
    localparam int A    = A_DEF;
    localparam int W    = W_DEF;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         write_en;
    logic [A-1:0] waddr;
    logic [W-1:0] data_in;
    logic         upp_or_low;
    logic         idle;
`ifdef REGARB_CONFLICT_CNT_EN
    logic [15:0]  conflict_cnt;
    logic [15:0]  cc_log [32];
`endif

    regfile_write_arbiter_if #(.NREQ(NREQ), .A(A), .W(W)) req_if ();

    regfile_write_arbiter #(.W(W), .A(A), .NREQ(NREQ)) dut (
        .Clk      (clk),
        .Reset    (rst_n),
        .req      (req_if),
        .WriteEn  (write_en),
        .Waddr    (waddr),
        .DataIn   (data_in),
        .UppOrLow (upp_or_low),
        .Idle     (idle)
`ifdef REGARB_CONFLICT_CNT_EN
        ,
        .ConflictCnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int      n_checks = 0;
    int      n_fail   = 0;
    wr_req_t exp_q [$];

    logic         we_log   [32];
    logic         idle_log [32];
    logic [W-1:0] data_log [32];
    int           stall0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (write_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h upp=%0b, expected no write at %0t",
                         waddr, data_in, upp_or_low, $time);
            end else begin
                wr_req_t got;
                wr_req_t exp;
                got = '{addr: waddr, data: data_in, upp_or_low: upp_or_low};
                exp = exp_q.pop_front();
                check("sb_write", 32'(got), 32'(exp));
            end
        end
    end

    task automatic drive(input int i, input wr_req_t r, input logic v);
        req_if.ReqValid[i]    = v;
        req_if.ReqAddr[i]     = r.addr;
        req_if.ReqData[i]     = r.data;
        req_if.ReqUppOrLow[i] = r.upp_or_low;
    endtask

    // Leaves the bench 1 time unit after the last reset edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n              = 1'b0;
        req_if.ReqValid    = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Must start just after an edge E(-1); log[t] is the state after edge E(t-1).
    task automatic stream(input int n0, input int n1, input wr_req_t s0, input wr_req_t s1,
                          input int cycles);
        int         cnt [2];
        int         lim [2];
        wr_req_t    cur [2];
        logic [1:0] hs;
        cnt[0] = 0;  cnt[1] = 0;
        lim[0] = n0; lim[1] = n1;
        cur[0] = s0; cur[1] = s1;
        stall0 = 0;
        drive(0, cur[0], n0 > 0);
        drive(1, cur[1], n1 > 0);
        for (int t = 0; t < cycles; t++) begin
            @(negedge clk);
            we_log[t]   = write_en;
            idle_log[t] = idle;
            data_log[t] = data_in;
`ifdef REGARB_CONFLICT_CNT_EN
            cc_log[t]   = conflict_cnt;
`endif
            hs = req_if.ReqValid & req_if.ReqReady;
            if (req_if.ReqValid[0] && !req_if.ReqReady[0]) stall0++;
            @(posedge clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (hs[i]) begin
                    cnt[i]++;
                    cur[i].data = cur[i].data + 8'd1;
                    drive(i, cur[i], cnt[i] < lim[i]);
                end
            end
        end
    endtask

    task automatic push(input logic [A-1:0] a, input logic [W-1:0] d, input logic u);
        exp_q.push_back('{addr: a, data: d, upp_or_low: u});
    endtask

    initial begin
        // 1: reset with both requesters offering
        rst_n = 1'b0;
        drive(0, '{addr: 2'd1, data: 8'hEE, upp_or_low: 1'b1}, 1'b1);
        drive(1, '{addr: 2'd3, data: 8'hDD, upp_or_low: 1'b0}, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        req_if.ReqValid = '0;
        rst_n           = 1'b1;
        @(negedge clk);
        check("t1_write_en", 32'(write_en), 32'd0);
        check("t1_idle", 32'(idle), 32'd1);
        check("t1_ready", 32'(req_if.ReqReady), 32'h3);
`ifdef REGARB_CONFLICT_CNT_EN
        check("t1_conflict_cnt", 32'(conflict_cnt), 32'd0);
`endif

        // 2: single write latency
        @(posedge clk);
        #1;
        drive(0, '{addr: 2'd2, data: 8'h5A, upp_or_low: 1'b1}, 1'b1);
        push(2'd2, 8'h5A, 1'b1);
        @(posedge clk);
        #1;
        req_if.ReqValid[0] = 1'b0;
        @(negedge clk);
        check("t2_not_yet", 32'(write_en), 32'd0);
        check("t2_slot_busy", 32'(idle), 32'd0);
        @(negedge clk);
        check("t2_write_en", 32'(write_en), 32'd1);
        check("t2_waddr", 32'(waddr), 32'd2);
        check("t2_data", 32'(data_in), 32'h5A);
        check("t2_upp", 32'(upp_or_low), 32'd1);
        @(negedge clk);
        check("t2_write_done", 32'(write_en), 32'd0);
        check("t2_idle", 32'(idle), 32'd1);

        // 3: both streaming, grants alternate
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push(2'd1, 8'(k), 1'b0);
            push(2'd3, 8'(8'h80 + k), 1'b1);
        end
        stream(4, 4, '{addr: 2'd1, data: 8'h00, upp_or_low: 1'b0},
                     '{addr: 2'd3, data: 8'h80, upp_or_low: 1'b1}, 12);
        check("t3_no_write_at_e0", 32'(we_log[1]), 32'd0);
        for (int k = 2; k <= 9; k++) check("t3_we_continuous", 32'(we_log[k]), 32'd1);
        check("t3_data0", 32'(data_log[2]), 32'h00);
        check("t3_data1", 32'(data_log[3]), 32'h80);
        check("t3_data2", 32'(data_log[4]), 32'h01);
        check("t3_data3", 32'(data_log[5]), 32'h81);
        check("t3_drained_we", 32'(we_log[10]), 32'd0);
        check("t3_drained_idle", 32'(idle_log[10]), 32'd1);

        // 4: req1 waits in its slot while req0 streams
        do_reset();
        push(2'd0, 8'h10, 1'b0);
        push(2'd2, 8'hC3, 1'b1);
        push(2'd0, 8'h11, 1'b0);
        push(2'd0, 8'h12, 1'b0);
        push(2'd0, 8'h13, 1'b0);
        stream(4, 1, '{addr: 2'd0, data: 8'h10, upp_or_low: 1'b0},
                     '{addr: 2'd2, data: 8'hC3, upp_or_low: 1'b1}, 8);
        check("t4_req1_granted_e2", 32'(data_log[3]), 32'hC3);
        check("t4_req0_stall", 32'(stall0), 32'd1);
        check("t4_idle_end", 32'(idle_log[7]), 32'd1);

        // 5: reset while both slots are full
        do_reset();
        drive(0, '{addr: 2'd1, data: 8'hA5, upp_or_low: 1'b0}, 1'b1);
        drive(1, '{addr: 2'd2, data: 8'h3C, upp_or_low: 1'b1}, 1'b1);
        @(posedge clk);
        #1;
        req_if.ReqValid = '0;
        rst_n           = 1'b0;
        @(negedge clk);
        check("t5_full_before", 32'(req_if.ReqReady), 32'h1);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t5_no_write", 32'(write_en), 32'd0);
            check("t5_idle", 32'(idle), 32'd1);
`ifdef REGARB_CONFLICT_CNT_EN
            check("t5_conflict_cnt", 32'(conflict_cnt), 32'd0);
`endif
        end

`ifdef REGARB_CONFLICT_CNT_EN
        // 6: conflict counting and saturation
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push(2'd0, 8'(8'h20 + k), 1'b0);
            if (k < 3) push(2'd1, 8'(8'hA0 + k), 1'b1);
        end
        stream(4, 3, '{addr: 2'd0, data: 8'h20, upp_or_low: 1'b0},
                     '{addr: 2'd1, data: 8'hA0, upp_or_low: 1'b1}, 10);
        check("t6_conflict_5", 32'(cc_log[6]), 32'd5);
        @(posedge clk);
        #1;
        force dut.conflict_cnt = 16'hFFFE;
        @(negedge clk);
        release dut.conflict_cnt;
        check("t6_preset", 32'(conflict_cnt), 32'hFFFE);
        @(posedge clk);
        #1;
        push(2'd2, 8'h40, 1'b0);
        push(2'd3, 8'hC0, 1'b1);
        push(2'd2, 8'h41, 1'b0);
        push(2'd3, 8'hC1, 1'b1);
        stream(2, 2, '{addr: 2'd2, data: 8'h40, upp_or_low: 1'b0},
                     '{addr: 2'd3, data: 8'hC0, upp_or_low: 1'b1}, 7);
        check("t6_first_conflict", 32'(cc_log[2]), 32'hFFFF);
        check("t6_saturated", 32'(conflict_cnt), 32'hFFFF);
`endif

        @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
